// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: takes one prefetch address at a time, reads the
// 32-bit word as four little-endian byte reads, and buffers word+PC pairs in a
// small FIFO whose head is presented to the issue stage. A flush empties the
// FIFO and abandons any fetch in progress.
module inst_fetch_queue #(
  parameter int DEPTH_LOG = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        is_prefetching,
  input  logic [31:0] prefetch_PC,
  output logic        prefetch_ready,
  input  logic        is_issuing,
  output logic        issue_valid,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_PC,
  output logic [31:0] mem_a,
  output logic        mem_rd,
  input  logic [7:0]  mem_din
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             cnt_reg;
  logic [31:0]            pc_reg;
  logic [2:0][7:0]        byte_reg;
  logic [DEPTH_LOG-1:0]   head_reg, tail_reg;
  logic [DEPTH_LOG:0]     count_reg;
  logic [31:0]            inst_q [DEPTH];
  logic [31:0]            pc_q   [DEPTH];

  logic accept, push, pop, fetch_done;
  logic [31:0] fetched_word;

  // The low address bits of a prefetch request carry no meaning: words are aligned.
  logic [1:0] unused_pc_bits;
  assign unused_pc_bits = prefetch_PC[1:0];

  // The fourth byte is taken straight off the bus on the completing edge.
  assign fetch_done   = (state_reg == FETCH) && (cnt_reg == 3'd4);
  assign fetched_word = {mem_din, byte_reg[2], byte_reg[1], byte_reg[0]};

  // Handshakes only complete while the system is running and not flushing.
  assign accept = rdy_in && !flush_pipline && is_prefetching && prefetch_ready;
  assign push   = rdy_in && !flush_pipline && fetch_done;
  assign pop    = rdy_in && !flush_pipline && is_issuing && issue_valid;

  // FSM state register, frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else if (rdy_in) begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: a flush always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    if (flush_pipline) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept)            state_next = FETCH;
        FETCH:   if (cnt_reg == 3'd4)   state_next = IDLE;
        default:                        state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: read strobe for byte slots 0..3, request handshake when a slot is free.
  always_comb begin
    mem_rd         = (state_reg == FETCH) && (cnt_reg < 3'd4);
    mem_a          = mem_rd ? (pc_reg + {29'd0, cnt_reg}) : 32'd0;
    prefetch_ready = !rst_in && (state_reg == IDLE) &&
                     (count_reg < (DEPTH_LOG + 1)'(DEPTH));
  end

  // Fetch datapath: latch the aligned PC, step the byte counter, collect returning bytes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_reg  <= 3'd0;
      pc_reg   <= 32'd0;
      byte_reg <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        cnt_reg <= 3'd0;
      end else if (accept) begin
        pc_reg  <= {prefetch_PC[31:2], 2'b00};
        cnt_reg <= 3'd0;
      end else if (state_reg == FETCH) begin
        // Data for the address driven at cnt arrives one cycle later, at cnt+1.
        if (cnt_reg != 3'd0 && cnt_reg != 3'd4) begin
          byte_reg[cnt_reg[1:0] - 2'd1] <= mem_din;
        end
        cnt_reg <= (cnt_reg == 3'd4) ? 3'd0 : cnt_reg + 3'd1;
      end
    end
  end

  // Queue entries: each slot loads the completed word when the tail points at it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          inst_q[gi] <= 32'd0;
          pc_q[gi]   <= 32'd0;
        end else if (push && (tail_reg == DEPTH_LOG'(gi))) begin
          inst_q[gi] <= fetched_word;
          pc_q[gi]   <= pc_reg;
        end
      end
    end
  endgenerate

  // Queue pointers and occupancy; simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + 1'b1;
        if (pop)  head_reg <= head_reg + 1'b1;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  assign issue_valid = (count_reg != '0);
  assign issue_inst  = inst_q[head_reg];
  assign issue_PC    = pc_q[head_reg];

endmodule
